// File: rtl/breakout_ball.sv
// Ball position, direction, lives and game state for a breakout game.
// Motion advances once per refresh_tick; bounce requests from the block columns are latched in between.
module breakout_ball #(
  parameter int BALL_SIZE  = 8,
  parameter int BALL_V     = 2,
  parameter int START_X    = 316,
  parameter int START_Y    = 240,
  parameter int PADDLE_Y_T = 440,
  parameter int LIVES      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        refresh_tick,
  input  logic        serve,
  input  logic        moveU,
  input  logic        moveD,
  input  logic        moveL,
  input  logic        moveR,
  input  logic [10:0] paddle_x_l,
  input  logic [10:0] paddle_x_r,
  input  logic [10:0] pix_x,
  input  logic [10:0] pix_y,
  output logic [10:0] ball_x_l,
  output logic [10:0] ball_x_r,
  output logic [10:0] ball_y_t,
  output logic [10:0] ball_y_b,
  output logic        ball_ON,
  output logic [1:0]  lives,
  output logic        ball_lost,
  output logic        game_over
);

  localparam logic [10:0] SZ    = 11'(BALL_SIZE - 1);
  localparam logic [10:0] V     = 11'(BALL_V);
  localparam logic [10:0] SX    = 11'(START_X);
  localparam logic [10:0] SY    = 11'(START_Y);
  localparam logic [10:0] PT    = 11'(PADDLE_Y_T);
  localparam logic [10:0] PB    = 11'(PADDLE_Y_T + 3);
  localparam logic [10:0] XMAX  = 11'(639 - BALL_V);
  localparam logic [10:0] YLOSS = 11'(479 - BALL_V);
  localparam logic [1:0]  L0    = 2'(LIVES);

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, y_q, x_d, y_d;
  logic        dxn_q, dyn_q, dxn_d, dyn_d;
  logic [3:0]  pend_q, pend_d;   // {U, D, L, R}
  logic [1:0]  lives_q, lives_d;
  logic        lost_q, lost_d;
  logic [3:0]  req;
  logic        nxn, nyn, loss, hit_paddle;

  assign ball_x_l = x_q;
  assign ball_x_r = x_q + SZ;
  assign ball_y_t = y_q;
  assign ball_y_b = y_q + SZ;

  assign game_over = (state_q == OVER);
  assign lives     = game_over ? 2'd0 : lives_q;
  assign ball_lost = lost_q;
  assign ball_ON   = (pix_x >= ball_x_l) && (pix_x <= ball_x_r) &&
                     (pix_y >= ball_y_t) && (pix_y <= ball_y_b) && !game_over;

  // Same-cycle pulses take part in this tick's resolution without being stored.
  assign req        = pend_q | {moveU, moveD, moveL, moveR};
  assign loss       = (ball_y_b >= YLOSS);
  assign hit_paddle = !dyn_q && (ball_y_b >= PT) && (ball_y_b <= PB) &&
                      (ball_x_r >= paddle_x_l) && (ball_x_l <= paddle_x_r);

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    dxn_d   = dxn_q;
    dyn_d   = dyn_q;
    pend_d  = pend_q;
    lives_d = lives_q;
    lost_d  = 1'b0;
    nxn     = dxn_q;
    nyn     = dyn_q;

    if      (x_q <= V)          nxn = 1'b0;
    else if (ball_x_r >= XMAX)  nxn = 1'b1;
    else if (req[1] && !req[0]) nxn = 1'b1;
    else if (req[0] && !req[1]) nxn = 1'b0;

    if      (y_q <= V)          nyn = 1'b0;
    else if (hit_paddle)        nyn = 1'b1;
    else if (req[3] && !req[2]) nyn = 1'b1;
    else if (req[2] && !req[3]) nyn = 1'b0;

    case (state_q)
      IDLE: begin
        x_d    = SX;
        y_d    = SY;
        dxn_d  = 1'b0;
        dyn_d  = 1'b1;
        pend_d = '0;
        if (refresh_tick && serve) begin
          state_d = PLAY;
          x_d     = SX + V;
          y_d     = SY - V;
        end
      end
      PLAY: begin
        if (refresh_tick) begin
          pend_d = '0;
          if (loss) begin
            lost_d  = 1'b1;
            lives_d = lives_q - 2'd1;
            state_d = (lives_q == 2'd1) ? OVER : IDLE;
            x_d     = SX;
            y_d     = SY;
            dxn_d   = 1'b0;
            dyn_d   = 1'b1;
          end else begin
            dxn_d = nxn;
            dyn_d = nyn;
            x_d   = nxn ? x_q - V : x_q + V;
            y_d   = nyn ? y_q - V : y_q + V;
          end
        end else begin
          pend_d = req;
        end
      end
      default: pend_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= SX;
      y_q     <= SY;
      dxn_q   <= 1'b0;
      dyn_q   <= 1'b1;
      pend_q  <= '0;
      lives_q <= L0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      dxn_q   <= dxn_d;
      dyn_q   <= dyn_d;
      pend_q  <= pend_d;
      lives_q <= lives_d;
      lost_q  <= lost_d;
    end
  end

endmodule

// File: tb/tb_breakout_ball.sv
// Directed bench for breakout_ball: a per-tick reference model pushes expectations
// into a queue that is popped and compared after each clock edge.
module tb_breakout_ball;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic [1:0]  lv;
    logic        lost;
    logic        over;
  } exp_t;

  logic        clk, reset, refresh_tick, serve;
  logic        moveU, moveD, moveL, moveR;
  logic [10:0] paddle_x_l, paddle_x_r, pix_x, pix_y;
  logic [10:0] ball_x_l, ball_x_r, ball_y_t, ball_y_b;
  logic        ball_ON, ball_lost, game_over;
  logic [1:0]  lives;

  breakout_ball dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick), .serve(serve),
    .moveU(moveU), .moveD(moveD), .moveL(moveL), .moveR(moveR),
    .paddle_x_l(paddle_x_l), .paddle_x_r(paddle_x_r), .pix_x(pix_x), .pix_y(pix_y),
    .ball_x_l(ball_x_l), .ball_x_r(ball_x_r), .ball_y_t(ball_y_t), .ball_y_b(ball_y_b),
    .ball_ON(ball_ON), .lives(lives), .ball_lost(ball_lost), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  // Reference model state: st 0=IDLE 1=PLAY 2=OVER, p = {U,D,L,R}
  int       m_x, m_y, m_lives, m_st;
  bit       m_dxn, m_dyn;
  bit [3:0] m_p;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_init();
    m_x = 316; m_y = 240; m_dxn = 0; m_dyn = 1; m_p = '0; m_lives = 3; m_st = 0;
  endtask

  task automatic model_tick(input bit u, d, l, r, srv, output exp_t e);
    bit [3:0] q;
    bit lost;
    lost = 0;
    if (m_st == 0) begin
      if (srv) begin m_st = 1; m_x = 318; m_y = 238; end
    end else if (m_st == 1) begin
      q = m_p | {u, d, l, r};
      m_p = '0;
      if (m_y + 7 >= 477) begin
        lost = 1; m_lives--; m_st = (m_lives == 0) ? 2 : 0;
        m_x = 316; m_y = 240; m_dxn = 0; m_dyn = 1;
      end else begin
        if (m_x <= 2) m_dxn = 0;
        else if (m_x + 7 >= 637) m_dxn = 1;
        else if (q[1] && !q[0]) m_dxn = 1;
        else if (q[0] && !q[1]) m_dxn = 0;
        if (m_y <= 2) m_dyn = 0;
        else if (!m_dyn && m_y + 7 >= 440 && m_y + 7 <= 443 &&
                 m_x + 7 >= int'(paddle_x_l) && m_x <= int'(paddle_x_r)) m_dyn = 1;
        else if (q[3] && !q[2]) m_dyn = 1;
        else if (q[2] && !q[3]) m_dyn = 0;
        m_x = m_dxn ? m_x - 2 : m_x + 2;
        m_y = m_dyn ? m_y - 2 : m_y + 2;
      end
    end
    e.x = 11'(m_x); e.y = 11'(m_y);
    e.lv = (m_st == 2) ? 2'd0 : 2'(m_lives);
    e.lost = lost; e.over = (m_st == 2);
  endtask

  task automatic do_tick(input bit u, d, l, r, srv);
    exp_t e;
    @(negedge clk);
    refresh_tick = 1; serve = srv; moveU = u; moveD = d; moveL = l; moveR = r;
    model_tick(u, d, l, r, srv, e);
    sb.push_back(e);
    @(posedge clk); #1;
    refresh_tick = 0; serve = 0; moveU = 0; moveD = 0; moveL = 0; moveR = 0;
    e = sb.pop_front();
    chk("x_l", ball_x_l, e.x);
    chk("x_r", ball_x_r, e.x + 11'd7);
    chk("y_t", ball_y_t, e.y);
    chk("y_b", ball_y_b, e.y + 11'd7);
    chk("lives", lives, e.lv);
    chk("ball_lost", ball_lost, e.lost);
    chk("game_over", game_over, e.over);
  endtask

  task automatic pulse(input bit u, d, l, r);
    @(negedge clk);
    moveU = u; moveD = d; moveL = l; moveR = r;
    if (m_st == 1) m_p = m_p | {u, d, l, r};
    @(posedge clk); #1;
    moveU = 0; moveD = 0; moveL = 0; moveR = 0;
  endtask

  task automatic run_to_loss(input string tag);
    int n;
    n = 0;
    while (m_st == 1 && n < 400) begin do_tick(0, 0, 0, 0, 0); n++; end
    chk(tag, n < 400, 1);
  endtask

  initial begin
    reset = 0; refresh_tick = 0; serve = 0;
    moveU = 0; moveD = 0; moveL = 0; moveR = 0;
    paddle_x_l = 11'd1000; paddle_x_r = 11'd1000; pix_x = 0; pix_y = 0;
    model_init();
    #12;
    chk("rst_x", ball_x_l, 316);
    chk("rst_y", ball_y_t, 240);
    chk("rst_lives", lives, 3);
    chk("rst_lost", ball_lost, 0);
    chk("rst_over", game_over, 0);
    @(negedge clk); reset = 1;

    // idle tick without serve changes nothing; serve launches up-right
    do_tick(0, 0, 0, 0, 0);
    do_tick(0, 0, 0, 0, 1);
    chk("serve_x", ball_x_l, 318);
    chk("serve_y", ball_y_t, 238);
    chk("serve_lives", lives, 3);

    // steer to (100,100) moving up-right
    do_tick(0, 0, 1, 0, 0);
    for (int i = 0; i < 68; i++) do_tick(0, 0, 0, 0, 0);
    chk("path_x", ball_x_l, 180);
    chk("path_y", ball_y_t, 100);
    for (int i = 0; i < 20; i++) begin do_tick(0, 1, 0, 0, 0); do_tick(1, 0, 0, 0, 0); end
    do_tick(0, 1, 0, 0, 0);
    do_tick(1, 0, 0, 1, 0);
    chk("at100_x", ball_x_l, 100);
    chk("at100_y", ball_y_t, 100);

    // sticky moveD, then U+D together leaves dy alone
    pulse(0, 1, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    chk("movD_x", ball_x_l, 102);
    chk("movD_y", ball_y_t, 102);
    pulse(1, 1, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    chk("movUD_y", ball_y_t, 104);

    // climb to y=2, pending U loses to the top wall
    do_tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 50; i++) do_tick(0, 0, 0, 0, 0);
    chk("top_y", ball_y_t, 2);
    pulse(1, 0, 0, 0);
    do_tick(0, 0, 0, 0, 0);
    chk("wall_y", ball_y_t, 4);
    do_tick(0, 0, 0, 0, 0);
    chk("wall_dy", ball_y_t, 6);

    // descend onto the paddle row; x-y stays a multiple of 4, so 322 is the reachable left edge
    while (m_y < 434) do_tick(0, 0, m_x >= 322, m_x < 322, 0);
    chk("pad_x", ball_x_l, 322);
    chk("pad_yb", ball_y_b, 441);
    paddle_x_l = 11'd300; paddle_x_r = 11'd380;
    do_tick(0, 0, 0, 0, 0);
    chk("pad_bounce_y", ball_y_t, 432);
    paddle_x_l = 11'd1000; paddle_x_r = 11'd1000;
    for (int i = 0; i < 19; i++) do_tick(0, 0, 0, 0, 0);
    do_tick(0, 1, 0, 0, 0);
    for (int i = 0; i < 19; i++) do_tick(0, 0, 0, 0, 0);
    chk("miss_x", ball_x_l, 402);
    chk("miss_yb", ball_y_b, 441);
    paddle_x_l = 11'd300; paddle_x_r = 11'd380;
    do_tick(0, 0, 0, 0, 0);
    chk("miss_y", ball_y_t, 436);
    paddle_x_l = 11'd1000; paddle_x_r = 11'd1000;

    // first loss
    run_to_loss("loss1_bound");
    chk("loss1_lives", lives, 2);
    chk("loss1_x", ball_x_l, 316);
    chk("loss1_y", ball_y_t, 240);
    @(posedge clk); #1;
    chk("loss1_pulse_end", ball_lost, 0);

    // ball_ON edges while idle
    pix_x = 11'd323; pix_y = 11'd247; #1;
    chk("on_corner", ball_ON, 1);
    pix_x = 11'd324; #1;
    chk("on_right_out", ball_ON, 0);
    pix_x = 11'd316; pix_y = 11'd239; #1;
    chk("on_top_out", ball_ON, 0);

    // second and third losses
    do_tick(0, 0, 0, 0, 1);
    do_tick(0, 1, 0, 0, 0);
    run_to_loss("loss2_bound");
    chk("loss2_lives", lives, 1);
    do_tick(0, 0, 0, 0, 1);
    do_tick(0, 1, 0, 0, 0);
    run_to_loss("loss3_bound");
    chk("over_flag", game_over, 1);
    chk("over_lives", lives, 0);
    pix_x = 11'd318; pix_y = 11'd242; #1;
    chk("over_ball_on", ball_ON, 0);
    do_tick(0, 0, 0, 0, 1);
    chk("over_serve_ignored", game_over, 1);

    // restart, then reset mid-play between edges with a pending moveL
    @(negedge clk); reset = 0; model_init();
    @(negedge clk); reset = 1;
    do_tick(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) do_tick(0, 0, 0, 0, 0);
    pulse(0, 0, 1, 0);
    @(posedge clk); #2;
    reset = 0; model_init(); #1;
    chk("mid_rst_x", ball_x_l, 316);
    chk("mid_rst_y", ball_y_t, 240);
    chk("mid_rst_lives", lives, 3);
    chk("mid_rst_lost", ball_lost, 0);
    chk("mid_rst_over", game_over, 0);
    @(negedge clk); reset = 1;
    do_tick(0, 0, 0, 0, 0);
    chk("post_rst_needs_serve", ball_x_l, 316);
    do_tick(0, 0, 0, 0, 1);
    do_tick(0, 0, 0, 0, 0);
    chk("post_rst_no_L", ball_x_l, 320);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/breakout_ball.md
BREAKOUT_BALL -- requirements
Module: breakout_ball

Interface
REQ-001 Parameters (name, default, meaning): BALL_SIZE, 8, ball edge length in pixels; BALL_V, 2, pixels moved per frame per axis; START_X, 316, ball_x_l at serve; START_Y, 240, ball_y_t at serve; PADDLE_Y_T, 440, paddle top row; LIVES, 3, balls per game.
REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  system clock; the block uses one clock.
- reset  in  1  asynchronous, active-low reset.
- refresh_tick  in  1  one-cycle pulse per video frame.
- serve  in  1  launch request (level).
- moveU, moveD, moveL, moveR  in  1 each  bounce requests from the block columns (ORed across columns), one-cycle pulses at any time.
- paddle_x_l, paddle_x_r  in  11  paddle horizontal extent.
- pix_x, pix_y  in  11  current scan pixel.
- ball_x_l, ball_x_r, ball_y_t, ball_y_b  out  11  ball edges, fed back to the block columns.
- ball_ON  out  1  ball pixel enable.
- lives  out  2  remaining balls.
- ball_lost  out  1  one-cycle pulse when a ball leaves the bottom.
- game_over  out  1  high once all lives are used.

Function
REQ-003 Position registers x, y; ball_x_l = x, ball_x_r = x+BALL_SIZE-1, ball_y_t = y, ball_y_b = y+BALL_SIZE-1. All arithmetic is 11-bit unsigned; no edge leaves the range 0..639 (x) or 0..479 (y) except at loss.
REQ-004 Direction is held as two sign bits, dx_neg and dy_neg. Speed magnitude is always BALL_V.
REQ-005 FSM states and transitions:
- IDLE -> PLAY on a refresh_tick with serve=1.
- PLAY -> IDLE on loss when lives>1.
- PLAY -> OVER on loss when lives==1.
- OVER is held until reset.
REQ-006 IDLE: x=START_X, y=START_Y, dx_neg=0, dy_neg=1. Pending flags are cleared and moveX inputs are ignored.
REQ-007 PLAY: each moveX pulse sets its sticky pending flag (pU, pD, pL, pR). All pending flags are cleared on the next refresh_tick.
REQ-008 PLAY, on refresh_tick, resolve the new direction per axis in this priority (highest first):
- Wall: x<=BALL_V -> dx_neg=0; ball_x_r>=639-BALL_V -> dx_neg=1; y<=BALL_V -> dy_neg=0.
- Paddle: dy_neg=0, ball_y_b in [PADDLE_Y_T, PADDLE_Y_T+3], ball_x_r>=paddle_x_l and ball_x_l<=paddle_x_r -> dy_neg=1.
- Pending: pU alone -> dy_neg=1; pD alone -> dy_neg=0; pL alone -> dx_neg=1; pR alone -> dx_neg=0. pU&pD or pL&pR -> that axis is unchanged.
REQ-009 In the same tick, apply x += or -= BALL_V and y += or -= BALL_V using the resolved direction. Position therefore lags the tick by 1 cycle.
REQ-010 Loss is detected on refresh_tick in PLAY when ball_y_b >= 479-BALL_V. On loss:
- no position update;
- ball_lost=1 for exactly one cycle;
- lives decrements;
- the next state follows REQ-005.
REQ-011 A moveX pulse in the same cycle as refresh_tick is applied on that tick and is not retained afterwards.
REQ-012 ball_ON = pix_x in [ball_x_l, ball_x_r] and pix_y in [ball_y_t, ball_y_b] and state != OVER. ball_ON is combinational.
REQ-013 game_over=1 exactly while the state is OVER. lives reads 0 in OVER.
REQ-014 serve is ignored outside IDLE. refresh_tick with serve=0 in IDLE changes nothing.

Reset
REQ-015 reset=0 immediately sets, regardless of clk:
- state=IDLE, x=316, y=240, dx_neg=0, dy_neg=1;
- all pending flags cleared;
- lives=LIVES, ball_lost=0, game_over=0.
REQ-016 Reset during PLAY or OVER discards all motion and pending requests. The first action after release requires a new serve.

Verification
REQ-017 The bench SHALL cover these scenarios:
- Reset, then serve=1 and one tick -> state PLAY, ball_x_l=318, ball_y_t=238, lives=3.
- In PLAY, ball at x=100, y=100 moving up-right; pulse moveD, then tick -> y=102, x=102. Pulse moveU and moveD together, then tick -> dy unchanged.
- Ball at y=2 moving up, with pU pending, then tick -> wall wins: dy_neg=0, y=4.
- Ball moving down, ball_y_b=441, paddle_x 300..380, ball_x_l=320, then tick -> dy_neg=1, y decreases by 2. Same with ball_x_l=400 -> no bounce.
- Ball_y_b reaches 477 with lives=3 -> one-cycle ball_lost, lives=2, IDLE, ball at (316,240). Repeat until lives=1 loss -> game_over=1, ball_ON=0, serve ignored.
- Assert reset mid-PLAY between clock edges -> outputs at reset values before the next clk edge; a pending moveL from before reset has no effect after the next serve.
